// File: rtl/multicycle_control_fsm_if.sv
// Bundles the control FSM's instruction/flag inputs and datapath control outputs.
//   master : IR/flag/memory side; drives op, funct3, Zero, mem_ready and consumes controls
//   slave  : the control FSM; consumes op/funct3/Zero/mem_ready and drives controls
interface multicycle_control_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [1:0] ALUOp;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state_dbg;

    modport master (
        output op, funct3, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
        input  RegWrite, ALUOp, instr_done, illegal, bus_err, state_dbg
    );

    modport slave (
        input  op, funct3, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
        output RegWrite, ALUOp, instr_done, illegal, bus_err, state_dbg
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences Fetch/Decode/Execute/Memory/Writeback over a
// shared ALU and one memory port, with a ready handshake, wait timeout and trap state.
//   clk     : rising-edge clock
//   reset   : synchronous, active-high
//   ctrl_if : slave modport; op/funct3/Zero/mem_ready in, datapath controls and
//             instr_done/illegal/bus_err/state_dbg out
module multicycle_control_fsm #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned WAIT_LIMIT    = 15,
    parameter int unsigned CNT_W         = 8
) (
    input logic                     clk,
    input logic                     reset,
    multicycle_control_fsm_if.slave ctrl_if
);

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpBr   = 7'b1100011;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [CNT_W-1:0] LastWait = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StJal    = 4'd10,
        StTrap   = 4'd11
    } state_e;

    state_e           r_state, w_state_d;
    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_d;
    logic             r_illegal, r_bus_err;

    logic       w_ready, w_waiting, w_timeout, w_set_illegal;
    logic       w_pcw, w_adr, w_mw, w_irw, w_rw, w_done;
    logic [1:0] w_rs, w_sa, w_sb, w_aop, w_imm;

    // Without the handshake, memory is assumed to always complete in one cycle.
    assign w_ready = MEM_HANDSHAKE ? ctrl_if.mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StFetch;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_timeout)     r_bus_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_waiting     = 1'b0;
        w_set_illegal = 1'b0;
        w_pcw         = 1'b0;
        w_adr         = 1'b0;
        w_mw          = 1'b0;
        w_irw         = 1'b0;
        w_rw          = 1'b0;
        w_done        = 1'b0;
        w_rs          = 2'b00;
        w_sa          = 2'b00;
        w_sb          = 2'b00;
        w_aop         = 2'b00;
        case (r_state)
            StFetch: begin
                w_waiting = 1'b1;
                w_sb      = 2'b10;
                w_rs      = 2'b10;
                w_irw     = w_ready;
                w_pcw     = w_ready;
                if (w_ready) w_state_d = StDecode;
            end
            StDecode: begin
                w_sa = 2'b01;
                w_sb = 2'b01;
                case (ctrl_if.op)
                    OpLw, OpSw: w_state_d = StMemAdr;
                    OpR:        w_state_d = StExecR;
                    OpI:        w_state_d = StExecI;
                    OpBr:       w_state_d = StBranch;
                    OpJal:      w_state_d = StJal;
                    default: begin
                        w_state_d     = StTrap;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                w_sa      = 2'b10;
                w_sb      = 2'b01;
                w_state_d = (ctrl_if.op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                w_waiting = 1'b1;
                w_adr     = 1'b1;
                if (w_ready) w_state_d = StMemWb;
            end
            StMemWb: begin
                w_rs      = 2'b01;
                w_rw      = 1'b1;
                w_done    = 1'b1;
                w_state_d = StFetch;
            end
            StMemWr: begin
                w_waiting = 1'b1;
                w_adr     = 1'b1;
                w_mw      = 1'b1;
                w_done    = w_ready;
                if (w_ready) w_state_d = StFetch;
            end
            StExecR: begin
                w_sa      = 2'b10;
                w_aop     = 2'b10;
                w_state_d = StAluWb;
            end
            StExecI: begin
                w_sa      = 2'b10;
                w_sb      = 2'b01;
                w_aop     = 2'b10;
                w_state_d = StAluWb;
            end
            StAluWb: begin
                w_rw      = 1'b1;
                w_done    = 1'b1;
                w_state_d = StFetch;
            end
            StBranch: begin
                w_sa      = 2'b10;
                w_aop     = 2'b01;
                // funct3[0] flips the sense: beq takes on Zero, bne on !Zero.
                w_pcw     = ctrl_if.Zero ^ ctrl_if.funct3[0];
                w_done    = 1'b1;
                w_state_d = StFetch;
            end
            StJal: begin
                w_sa      = 2'b01;
                w_sb      = 2'b10;
                w_pcw     = 1'b1;
                w_state_d = StAluWb;
            end
            StTrap:  w_state_d = StTrap;
            default: w_state_d = StTrap;
        endcase
        // Timeout fires on the WAIT_LIMIT-th consecutive not-ready cycle; ready wins a tie.
        w_timeout = MEM_HANDSHAKE && w_waiting && !w_ready && (r_wait_cnt == LastWait);
        if (w_timeout) w_state_d = StTrap;
    end

    always_comb begin
        w_wait_cnt_d = '0;
        if (MEM_HANDSHAKE && w_waiting && !w_ready && (w_state_d == r_state)) begin
            w_wait_cnt_d = r_wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        case (ctrl_if.op)
            OpSw:    w_imm = 2'b01;
            OpBr:    w_imm = 2'b10;
            OpJal:   w_imm = 2'b11;
            default: w_imm = 2'b00;
        endcase
    end

    // Strobes are suppressed during reset so an aborted instruction cannot write anything.
    assign ctrl_if.PCWrite    = w_pcw & ~reset;
    assign ctrl_if.MemWrite   = w_mw & ~reset;
    assign ctrl_if.IRWrite    = w_irw & ~reset;
    assign ctrl_if.RegWrite   = w_rw & ~reset;
    assign ctrl_if.instr_done = w_done & ~reset;
    assign ctrl_if.AdrSrc     = w_adr;
    assign ctrl_if.ResultSrc  = w_rs;
    assign ctrl_if.ALUSrcA    = w_sa;
    assign ctrl_if.ALUSrcB    = w_sb;
    assign ctrl_if.ALUOp      = w_aop;
    assign ctrl_if.ImmSrc     = w_imm;
    assign ctrl_if.illegal    = r_illegal;
    assign ctrl_if.bus_err    = r_bus_err;
    assign ctrl_if.state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a table of per-cycle vectors for the
// zero-wait instruction flows, then hand-written wait/timeout/trap/reset sequences.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // exp = {state[3:0], PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc[1:0], ALUSrcA[1:0],
    //        ALUSrcB[1:0], ImmSrc[1:0], RegWrite, ALUOp[1:0], instr_done, illegal, bus_err}
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        zero;
        logic        rdy;
        logic [21:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(
        .MEM_HANDSHAKE (1'b1),
        .WAIT_LIMIT    (15),
        .CNT_W         (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_if (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [6:0] op, int f3, int z, int rdy, int st, int pcw,
                                int adr, int mw, int irw, int rs, int sa, int sb, int imm,
                                int rw, int aop, int done);
        vec_t v;
        v.op   = op;
        v.f3   = 3'(f3);
        v.zero = 1'(z);
        v.rdy  = 1'(rdy);
        v.exp  = {4'(st), 1'(pcw), 1'(adr), 1'(mw), 1'(irw), 2'(rs), 2'(sa), 2'(sb), 2'(imm),
                  1'(rw), 2'(aop), 1'(done), 2'b00};
        return v;
    endfunction

    function automatic logic [21:0] act_vec();
        return {bus.state_dbg, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegWrite, bus.ALUOp,
                bus.instr_done, bus.illegal, bus.bus_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; DUT is sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic z,
                          input logic rdy);
        bus.op        = op;
        bus.funct3    = f3;
        bus.Zero      = z;
        bus.mem_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        int strobes;
        logic [7:0] rd_pat;

        // R-type, with two stalled fetch cycles first
        vecs.push_back(mk(OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(OP_R, 0, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(OP_R, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(OP_R, 0, 0, 1, 6, 0, 0, 0, 0, 0, 2, 0, 0, 0, 2, 0));
        vecs.push_back(mk(OP_R, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        // I-ALU
        vecs.push_back(mk(OP_I, 0, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(OP_I, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(OP_I, 0, 0, 1, 7, 0, 0, 0, 0, 0, 2, 1, 0, 0, 2, 0));
        vecs.push_back(mk(OP_I, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        // lw, zero wait
        vecs.push_back(mk(OP_LW, 2, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(OP_LW, 2, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(OP_LW, 2, 0, 1, 2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(OP_LW, 2, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_LW, 2, 0, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
        // sw, zero wait
        vecs.push_back(mk(OP_SW, 2, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(OP_SW, 2, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(OP_SW, 2, 0, 1, 2, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(OP_SW, 2, 0, 1, 5, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        // beq taken (Zero=1)
        vecs.push_back(mk(OP_BR, 0, 1, 1, 0, 1, 0, 0, 1, 2, 0, 2, 2, 0, 0, 0));
        vecs.push_back(mk(OP_BR, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(OP_BR, 0, 1, 1, 9, 1, 0, 0, 0, 0, 2, 0, 2, 0, 1, 1));
        // beq not taken (Zero=0)
        vecs.push_back(mk(OP_BR, 0, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 2, 0, 0, 0));
        vecs.push_back(mk(OP_BR, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(OP_BR, 0, 0, 1, 9, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 1));
        // bne taken (Zero=0)
        vecs.push_back(mk(OP_BR, 1, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 2, 0, 0, 0));
        vecs.push_back(mk(OP_BR, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(OP_BR, 1, 0, 1, 9, 1, 0, 0, 0, 0, 2, 0, 2, 0, 1, 1));
        // bne not taken (Zero=1)
        vecs.push_back(mk(OP_BR, 1, 1, 1, 0, 1, 0, 0, 1, 2, 0, 2, 2, 0, 0, 0));
        vecs.push_back(mk(OP_BR, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(OP_BR, 1, 1, 1, 9, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 1));
        // jal
        vecs.push_back(mk(OP_JAL, 0, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 3, 0, 0, 0));
        vecs.push_back(mk(OP_JAL, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0));
        vecs.push_back(mk(OP_JAL, 0, 0, 1, 10, 1, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0));
        vecs.push_back(mk(OP_JAL, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 1));
        vecs.push_back(mk(OP_JAL, 0, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 3, 0, 0, 0));

        // Reset state; write strobes are held low while reset is high
        set_in(OP_R, 3'b000, 1'b0, 1'b1);
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        check("reset_state", 32'(bus.state_dbg), 32'd0);
        check("reset_flags", {30'd0, bus.illegal, bus.bus_err}, 32'd0);
        check("reset_gates_strobes", {30'd0, bus.PCWrite, bus.IRWrite}, 32'd0);
        next_cycle();
        reset = 1'b0;

        // Table-driven flows
        foreach (vecs[i]) begin
            set_in(vecs[i].op, vecs[i].f3, vecs[i].zero, vecs[i].rdy);
            @(negedge clk);
            check($sformatf("row%0d", i), 32'(act_vec()), 32'(vecs[i].exp));
            next_cycle();
        end

        // lw with 3 not-ready cycles in MEMRD: AdrSrc held 4 cycles, MEMWB at cycle 7
        do_reset();
        rd_pat = 8'b1100_0111;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            set_in(OP_LW, 3'b010, 1'b0, rd_pat[c]);
            @(negedge clk);
            if (bus.AdrSrc) cnt++;
            if (c == 7) begin
                check("lw_wait_memwb_state", 32'(bus.state_dbg), 32'd4);
                check("lw_wait_wb_ctrl", {29'd0, bus.RegWrite, bus.ResultSrc}, 32'b101);
            end
            next_cycle();
        end
        check("lw_wait_adrsrc_cycles", 32'(cnt), 32'd4);

        // sw with mem_ready stuck low: 15 MemWrite cycles then TRAP with bus_err
        do_reset();
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            set_in(OP_SW, 3'b010, 1'b0, (c == 0));
            @(negedge clk);
            if (bus.state_dbg == 4'd11) break;
            if (bus.MemWrite) cnt++;
            next_cycle();
        end
        check("sw_timeout_trap_state", 32'(bus.state_dbg), 32'd11);
        check("sw_timeout_memwrite_cycles", 32'(cnt), 32'd15);
        check("sw_timeout_bus_err", 32'(bus.bus_err), 32'd1);
        check("sw_timeout_memwrite_off", 32'(bus.MemWrite), 32'd0);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            bus.mem_ready = 1'b1;
            @(negedge clk);
            if (bus.state_dbg != 4'd11 || !bus.bus_err) cnt++;
        end
        check("trap_absorbing", 32'(cnt), 32'd0);
        next_cycle();
        do_reset();
        @(negedge clk);
        check("bus_err_cleared", {28'd0, bus.state_dbg, bus.bus_err}, 32'd0);
        next_cycle();

        // Ready on the last allowed wait cycle wins over the timeout
        do_reset();
        for (int c = 0; c < 14; c++) begin
            set_in(OP_R, 3'b000, 1'b0, 1'b0);
            next_cycle();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("race_still_fetch", 32'(bus.state_dbg), 32'd0);
        next_cycle();
        @(negedge clk);
        check("race_advance", {27'd0, bus.state_dbg, bus.bus_err}, {27'd0, 4'd1, 1'b0});
        next_cycle();

        // Illegal opcode: DECODE -> TRAP, sticky illegal, no strobes; reset clears
        do_reset();
        set_in(OP_BAD, 3'b000, 1'b0, 1'b1);
        next_cycle();
        @(negedge clk);
        check("illegal_decode", {27'd0, bus.state_dbg, bus.illegal}, {27'd0, 4'd1, 1'b0});
        strobes = 0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            if (bus.PCWrite || bus.IRWrite || bus.MemWrite || bus.RegWrite || bus.instr_done)
                strobes++;
        end
        check("illegal_trap", {27'd0, bus.state_dbg, bus.illegal}, {27'd0, 4'd11, 1'b1});
        check("illegal_no_strobes", 32'(strobes), 32'd0);
        next_cycle();
        do_reset();
        @(negedge clk);
        check("illegal_cleared", {27'd0, bus.state_dbg, bus.illegal}, 32'd0);
        next_cycle();

        // Reset during MEMWR aborts the store with no MemWrite in the reset cycle
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(OP_SW, 3'b010, 1'b0, (c == 0));
            next_cycle();
        end
        @(negedge clk);
        check("abort_in_memwr", {27'd0, bus.state_dbg, bus.MemWrite}, {27'd0, 4'd5, 1'b1});
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("abort_no_memwrite", {27'd0, bus.state_dbg, bus.MemWrite}, {27'd0, 4'd5, 1'b0});
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("abort_to_fetch", 32'(bus.state_dbg), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states over a shared ALU and a single unified memory port.
- Adds a memory ready handshake with a parametrised timeout, bne support, illegal-opcode trapping and a retire pulse.
- Sits between the instruction register/flag logic and the shared datapath muxes.

Parameters:
- MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = mem_ready is treated as constant 1.
- WAIT_LIMIT, 15, consecutive not-ready cycles allowed before bus-error trap (1..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  7  instruction opcode field (from IR)
- funct3  in  3  instruction funct3 field (from IR)
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = Imm, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  register file write enable
- ALUOp  out  2  00 = add, 01 = sub, 10 = by funct
- instr_done  out  1  one-cycle retire pulse
- illegal  out  1  sticky: illegal opcode
- bus_err  out  1  sticky: memory timeout
- state_dbg  out  4  current state encoding

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Synchronous active-high reset: on reset, state goes to FETCH, the wait counter, illegal and bus_err clear, and all registered flags are 0.
  - Reset mid-instruction aborts it; no write strobe is asserted in the reset cycle.
- Output style:
  - Outputs are Moore functions of state, except that mem_ready gates write enables (below) and PCWrite includes the branch term.
  - Any output not listed for a state is 0 (ResultSrc, ALUSrcA, ALUSrcB and ALUOp default to 00).
- ImmSrc is decoded from op only, in every state: lw/I-ALU = 00, sw = 01, branch = 10, jal = 11, others = 00.
- Opcodes: R = 0110011, I-ALU = 0010011, lw = 0000011, sw = 0100011, branch = 1100011, jal = 1101111.
- States and encoding:
  - FETCH = 0: ALUSrcB = 10, ResultSrc = 10, IRWrite = PCWrite = mem_ready. Advances to DECODE only when mem_ready, else holds.
  - DECODE = 1: ALUSrcA = 01, ALUSrcB = 01 (branch target computed into ALUOut). Next state by op: lw/sw -> MEMADR, R -> EXECR, I-ALU -> EXECI, branch -> BRANCH, jal -> JAL, any other -> TRAP with illegal set.
  - MEMADR = 2: ALUSrcA = 10, ALUSrcB = 01. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD = 3: AdrSrc = 1. Holds until mem_ready, then MEMWB.
  - MEMWB = 4: ResultSrc = 01, RegWrite = 1, instr_done = 1. Next FETCH.
  - MEMWR = 5: AdrSrc = 1, MemWrite = 1 held until mem_ready. On mem_ready, instr_done = 1 and next FETCH.
  - EXECR = 6: ALUSrcA = 10, ALUOp = 10. Next ALUWB.
  - EXECI = 7: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Next ALUWB.
  - ALUWB = 8: RegWrite = 1, instr_done = 1. Next FETCH.
  - BRANCH = 9: ALUSrcA = 10, ALUOp = 01, PCWrite = Zero XOR funct3[0] (beq and bne), instr_done = 1. Next FETCH.
  - JAL = 10: ALUSrcA = 01, ALUSrcB = 10, PCWrite = 1. Next ALUWB.
  - TRAP = 11: all enables 0, absorbing until reset.
- Wait counter:
  - Counts consecutive cycles in FETCH/MEMRD/MEMWR with mem_ready = 0; clears on mem_ready or any state change.
  - When the count reaches WAIT_LIMIT while still not ready, the next state is TRAP and bus_err is set.
  - If mem_ready arrives in the same cycle the limit would be reached, it wins: normal advance.
- Latency with zero wait states (cycles from FETCH to next FETCH): lw 5, sw 4, R 4, I-ALU 4, branch 3, jal 4.
- With MEM_HANDSHAKE = 0: bus_err is never set and the counter is held at 0.

Test Plan:
- reset, op = 0110011, mem_ready = 1 -> states 0,1,6,8,0; RegWrite = 1 only in ALUWB; instr_done pulse at cycle 4.
- op = 0000011, mem_ready low 3 cycles in MEMRD -> AdrSrc = 1 held 4 cycles; MEMWB reached at cycle 7; RegWrite with ResultSrc = 01.
- op = 1100011, funct3 = 001, Zero = 0 -> PCWrite = 1 in BRANCH; with Zero = 1 -> PCWrite = 0.
- op = 0100011, mem_ready stuck 0, WAIT_LIMIT = 15 -> MemWrite held 15 cycles, then TRAP, bus_err = 1, MemWrite = 0; held until reset.
- op = 1111111 -> DECODE -> TRAP, illegal = 1, no write strobes; reset asserted -> state 0, illegal = 0 next cycle.
- op = 1101111 -> states 0,1,10,8,0; PCWrite = 1 in JAL with ALUSrcA = 01, ALUSrcB = 10; ImmSrc = 11 throughout.
